sbc32_seq: RTL and testbench

- Multi-cycle subtract-with-borrow unit. It computes D = {1'b0,A} - {1'b0,B} - Bin, the inverse operation of the 32-bit add-with-carry datapath adder.
- Processes DIGIT bits per clock, LSB first, under a start/done handshake.
- Sits beside the ALU as the low-area subtraction path. It is also the self-check partner for adder benches: for any A, B and borrow/carry-in, ADC(D[WIDTH-1:0], B) must return A.

---
 rtl/sbc32_pkg.sv | 18 +
 rtl/sbc_digit.sv | 19 +
 rtl/sbc32_seq.sv | 125 ++++++++++++
 tb/tb_sbc32_seq.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/sbc32_pkg.sv
// Shared definitions for the sequential subtract-with-borrow unit:
// state encoding, default geometry and the digit-count helper.
package sbc32_pkg;

    localparam int WIDTH_DEF = 32;
    localparam int DIGIT_DEF = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int n_digits(input int width, input int digit);
        return width / digit;
    endfunction

endpackage

// File: rtl/sbc_digit.sv
// One DIGIT-wide subtract-with-borrow slice; bout is set when the slice
// result went negative.
module sbc_digit #(
    parameter int DIGIT = 4
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    input  logic             bin,
    output logic [DIGIT-1:0] d,
    output logic             bout
);

    logic [DIGIT:0] diff;

    assign diff = {1'b0, a} - {1'b0, b} - {{DIGIT{1'b0}}, bin};
    assign d    = diff[DIGIT-1:0];
    assign bout = diff[DIGIT];

endmodule

// File: rtl/sbc32_seq.sv
// Multi-cycle subtract-with-borrow, DIGIT bits per clock, LSB first.
// Optional signed-overflow output V enabled by defining SBC32_SEQ_OVF_EN.
module sbc32_seq
    import sbc32_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int DIGIT = DIGIT_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH:0]   D
`ifdef SBC32_SEQ_OVF_EN
    ,
    output logic             V
`endif
);

    localparam int N  = n_digits(WIDTH, DIGIT);
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] res_sh;
    logic             brw;
    logic [CW-1:0]    cnt;

    logic [DIGIT-1:0]       dig_d;
    logic                   dig_bout;
    logic [WIDTH+DIGIT-1:0] res_cat;
    logic [WIDTH-1:0]       res_next;
    logic                   last_digit;

    sbc_digit #(
        .DIGIT(DIGIT)
    ) u_digit (
        .a   (a_sh[DIGIT-1:0]),
        .b   (b_sh[DIGIT-1:0]),
        .bin (brw),
        .d   (dig_d),
        .bout(dig_bout)
    );

    // New digit enters at the MSB end; concatenation keeps DIGIT == WIDTH legal.
    assign res_cat    = {dig_d, res_sh};
    assign res_next   = res_cat[WIDTH+DIGIT-1:DIGIT];
    assign last_digit = (cnt == CW'(N - 1));

`ifdef SBC32_SEQ_OVF_EN
    logic a_msb;
    logic b_msb;
    logic v_q;

    assign V = v_q;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
            D      <= '0;
            a_sh   <= '0;
            b_sh   <= '0;
            res_sh <= '0;
            brw    <= 1'b0;
            cnt    <= '0;
`ifdef SBC32_SEQ_OVF_EN
            a_msb  <= 1'b0;
            b_msb  <= 1'b0;
            v_q    <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_sh   <= A;
                        b_sh   <= B;
                        brw    <= Bin;
                        res_sh <= '0;
                        cnt    <= '0;
                        busy   <= 1'b1;
                        state  <= RUN;
`ifdef SBC32_SEQ_OVF_EN
                        a_msb  <= A[WIDTH-1];
                        b_msb  <= B[WIDTH-1];
`endif
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    a_sh   <= a_sh >> DIGIT;
                    b_sh   <= b_sh >> DIGIT;
                    brw    <= dig_bout;
                    res_sh <= res_next;
                    cnt    <= cnt + 1'b1;
                    // D and V only ever change here, so partial results stay hidden.
                    if (last_digit) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        D     <= {dig_bout, res_next};
`ifdef SBC32_SEQ_OVF_EN
                        v_q   <= (a_msb != b_msb) && (res_next[WIDTH-1] != a_msb);
`endif
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sbc32_seq.sv
// Scoreboard bench for sbc32_seq: driver pushes expected results at each
// accepted start, a negedge monitor checks busy/done/D (and V when enabled).
module tb_sbc32_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] A = '0;
    logic [31:0] B = '0;
    logic        Bin = 1'b0;
    logic        busy;
    logic        done;
    logic [32:0] D;
`ifdef SBC32_SEQ_OVF_EN
    logic        V;
`endif

    always #5 clk = ~clk;

    sbc32_seq #(
        .WIDTH(32),
        .DIGIT(4)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .start(start),
        .A    (A),
        .B    (B),
        .Bin  (Bin),
        .busy (busy),
        .done (done),
        .D    (D)
`ifdef SBC32_SEQ_OVF_EN
        ,
        .V    (V)
`endif
    );

    typedef struct {
        logic [32:0] d;
        logic        v;
        int          acc;
    } sb_t;

    sb_t         q[$];
    int          checks = 0;
    int          errors = 0;
    int          neg_cnt = 0;
    logic [32:0] last_d = '0;
    logic        last_v = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: full-precision integer difference, result taken modulo 2^33;
    // V from the operand/result sign rule.
    function automatic sb_t model(input logic [31:0] a, input logic [31:0] b,
                                  input logic bi, input int acc);
        sb_t    e;
        longint diff;
        diff  = longint'(a) - longint'(b) - longint'(bi);
        e.d   = diff[32:0];
        e.v   = (a[31] != b[31]) && (e.d[31] != a[31]);
        e.acc = acc;
        return e;
    endfunction

    // Monitor: done is due exactly 8 sampled cycles after the first busy cycle.
    always @(negedge clk) begin : mon
        logic exp_busy;
        logic exp_done;
        neg_cnt++;
        exp_busy = (q.size() > 0) && (neg_cnt >= q[0].acc) && (neg_cnt < q[0].acc + 8);
        exp_done = (q.size() > 0) && (neg_cnt == q[0].acc + 8);
        check("busy", 64'(busy), 64'(exp_busy));
        check("done", 64'(done), 64'(exp_done));
        if (exp_done) begin
            check("D", 64'(D), 64'(q[0].d));
`ifdef SBC32_SEQ_OVF_EN
            check("V", 64'(V), 64'(q[0].v));
`endif
            last_d = q[0].d;
            last_v = q[0].v;
            void'(q.pop_front());
        end else begin
            check("D_hold", 64'(D), 64'(last_d));
`ifdef SBC32_SEQ_OVF_EN
            check("V_hold", 64'(V), 64'(last_v));
`endif
        end
    end

    task automatic wait_idle();
        int k = 0;
        while ((q.size() != 0 || busy) && k < 200) begin
            @(posedge clk);
            #1;
            k++;
        end
        if (k >= 200) begin
            checks++;
            errors++;
            $display("FAIL wait_idle: still busy=%0b pending=%0d, required idle", busy, q.size());
            q.delete();
        end
    endtask

    task automatic accept_and_push(input sb_t e);
        q.push_back(e);
        start = 1'b0;
        A     = $urandom;
        B     = $urandom;
        Bin   = 1'($urandom_range(0, 1));
    endtask

    task automatic issue_exp(input logic [31:0] a, input logic [31:0] b, input logic bi,
                             input logic [32:0] exp_d, input logic exp_v);
        sb_t e;
        wait_idle();
        A = a; B = b; Bin = bi; start = 1'b1;
        @(posedge clk);
        #1;
        e.d = exp_d; e.v = exp_v; e.acc = neg_cnt + 1;
        accept_and_push(e);
    endtask

    task automatic issue_rand();
        logic [31:0] a, b;
        logic        bi;
        a  = $urandom;
        b  = ($urandom_range(0, 3) == 0) ? a : $urandom;
        bi = 1'($urandom_range(0, 1));
        wait_idle();
        A = a; B = b; Bin = bi; start = 1'b1;
        @(posedge clk);
        #1;
        accept_and_push(model(a, b, bi, neg_cnt + 1));
    endtask

    task automatic back_to_back();
        int  k;
        sb_t e;
        issue_exp(32'h0000_1000, 32'h0000_0001, 1'b0, 33'h0_00000FFF, 1'b0);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        A = 32'hFFFF_FFFF; B = 32'h0; Bin = 1'b1; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        A = 32'h8000_0000; B = 32'h1; Bin = 1'b0; start = 1'b1;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!done && k < 30);
        if (k >= 30) begin
            checks++;
            errors++;
            $display("FAIL b2b_done: done never seen within %0d cycles, required within 8", k);
        end
        @(posedge clk);
        #1;
        e.d = 33'h0_7FFFFFFF; e.v = 1'b1; e.acc = neg_cnt + 1;
        accept_and_push(e);
    endtask

    task automatic reset_mid_run();
        issue_rand();
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_D", 64'(D), 64'd0);
`ifdef SBC32_SEQ_OVF_EN
        check("rst_V", 64'(V), 64'd0);
`endif
        q.delete();
        last_d = '0;
        last_v = 1'b0;
        #1;
        rst_n = 1'b1;
        repeat (12) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #12;
        check("init_busy", 64'(busy), 64'd0);
        check("init_done", 64'(done), 64'd0);
        check("init_D", 64'(D), 64'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        issue_exp(32'hA5A5_A5A5, 32'h1111_1111, 1'b0, 33'h0_94949494, 1'b0);
        issue_exp(32'hA5A5_A5A5, 32'h1111_1111, 1'b1, 33'h0_94949493, 1'b0);
        issue_exp(32'h0000_0000, 32'h0000_0001, 1'b0, 33'h1_FFFFFFFF, 1'b0);
        issue_exp(32'h0000_0000, 32'h0000_0000, 1'b1, 33'h1_FFFFFFFF, 1'b0);
        issue_exp(32'h1234_5678, 32'h1234_5678, 1'b0, 33'h0_00000000, 1'b0);
        issue_exp(32'h1234_5678, 32'h1234_5678, 1'b1, 33'h1_FFFFFFFF, 1'b0);
        issue_exp(32'h0000_0005, 32'h0000_0003, 1'b0, 33'h0_00000002, 1'b0);
        issue_exp(32'h8000_0000, 32'h0000_0001, 1'b0, 33'h0_7FFFFFFF, 1'b1);

        back_to_back();
        wait_idle();

        reset_mid_run();
        issue_exp(32'hFFFF_FFFF, 32'h0000_0001, 1'b1, 33'h0_FFFFFFFD, 1'b0);

        for (int i = 0; i < 40; i++) begin
            issue_rand();
        end
        wait_idle();
        repeat (3) @(posedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation still running at %0t, required to finish", $time);
        $fatal(1, "timeout");
    end

endmodule
